// File: rtl/i2s_output.sv
// i2s_output: Philips I2S master transmitter for an external DAC.
// Accepts 32-bit stereo words ({left[15:0], right[15:0]}) over stb/ack into a
// one-word holding buffer. It also generates the codec master clock, the bit
// clock and the word clock, and shifts out one word per 64-slot frame.
// Optional feature macro: I2S_OUTPUT_UNDERRUN_COUNT_EN adds a saturating 16-bit
// underrun counter on underrun_count_out.
module i2s_output #(
   parameter int MCLK_DIV = 2,
   parameter int BCLK_DIV = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in1,
   input  logic        in1_stb,
   output logic        in1_ack,
   output logic        sclk_out,
   output logic        bclk_out,
   output logic        lrclk_out,
   output logic        dout_out,
`ifdef I2S_OUTPUT_UNDERRUN_COUNT_EN
   output logic [15:0] underrun_count_out,
`endif
   output logic        underrun_out
);

   localparam int DATA_W = 32;
   localparam int MW     = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
   localparam int BW     = $clog2(BCLK_DIV);

   logic [MW-1:0]     mcnt;
   logic [BW-1:0]     div;
   logic [5:0]        k;
   logic [5:0]        k_next;
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] hold;
   logic              full;
   logic              fall_evt;
   logic              frame_load;
   logic              capture;
   logic              data_slot;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Event decode: bclk falling toggle, slot advance, frame start, buffer capture
   always_comb begin
      fall_evt   = bclk_out && (div == BW'(BCLK_DIV - 1));
      k_next     = k + 6'd1;
      frame_load = fall_evt && (k_next == 6'd0);
      capture    = in1_stb && !full;
      data_slot  = ((k_next >= 6'd1)  && (k_next <= 6'd16)) ||
                   ((k_next >= 6'd33) && (k_next <= 6'd48));
   end

   // Free-running codec master clock, independent of the bit clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt     <= '0;
         sclk_out <= 1'b0;
      end else if (mcnt == MW'(MCLK_DIV - 1)) begin
         mcnt     <= '0;
         sclk_out <= ~sclk_out;
      end else begin
         mcnt <= mcnt + MW'(1);
      end
   end

   // Bit clock divider: toggle at terminal count of div
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div      <= '0;
         bclk_out <= 1'b0;
      end else if (div == BW'(BCLK_DIV - 1)) begin
         div      <= '0;
         bclk_out <= ~bclk_out;
      end else begin
         div <= div + BW'(1);
      end
   end

   // Slot counter, word clock and serial data, all moving on bclk falling events;
   // data lags the word clock by one slot (I2S one-bit delay)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k            <= 6'd63;
         lrclk_out    <= 1'b0;
         dout_out     <= 1'b0;
         sreg         <= '0;
         underrun_out <= 1'b0;
      end else begin
         underrun_out <= 1'b0;
         if (fall_evt) begin
            k         <= k_next;
            lrclk_out <= k_next[5];
            if (k_next == 6'd0) begin
               // an empty buffer at frame start plays silence
               sreg         <= full ? hold : '0;
               underrun_out <= !full;
               dout_out     <= 1'b0;
            end else if (data_slot) begin
               dout_out <= sreg[DATA_W-1];
               sreg     <= {sreg[DATA_W-2:0], 1'b0};
            end else begin
               dout_out <= 1'b0;
            end
         end
      end
   end

   // Holding-buffer occupancy and ack; a capture coinciding with a frame load
   // wins because the load has already taken the previous contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full    <= 1'b0;
         in1_ack <= 1'b0;
      end else begin
         in1_ack <= capture;
         if (capture) begin
            full <= 1'b1;
         end else if (frame_load) begin
            full <= 1'b0;
         end
      end
   end

   // Holding-buffer data; only meaningful while full is set, so it needs no reset
   always_ff @(posedge clk) begin
      if (capture) begin
         hold <= in1;
      end
   end

`ifdef I2S_OUTPUT_UNDERRUN_COUNT_EN
   // Saturating count of frames started without a buffered word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_count_out <= 16'd0;
      end else if (frame_load && !full) begin
         underrun_count_out <= sat_inc(underrun_count_out);
      end
   end
`endif

endmodule

// File: tb/tb_i2s_output.sv
// Self-checking bench for i2s_output (BCLK_DIV=2, MCLK_DIV=1).
// A cycle-indexed reference model predicts every output from elapsed cycles
// and frame contents; directed scenarios pin the model with literal values.
module tb_i2s_output;
   localparam int MCLK_DIV = 1;
   localparam int BCLK_DIV = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in1;
   logic        in1_stb;
   logic        in1_ack, sclk_out, bclk_out, lrclk_out, dout_out, underrun_out;
`ifdef I2S_OUTPUT_UNDERRUN_COUNT_EN
   logic [15:0] underrun_count_out;
`endif

   i2s_output #(.MCLK_DIV(MCLK_DIV), .BCLK_DIV(BCLK_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .in1(in1), .in1_stb(in1_stb), .in1_ack(in1_ack),
      .sclk_out(sclk_out), .bclk_out(bclk_out), .lrclk_out(lrclk_out),
      .dout_out(dout_out),
`ifdef I2S_OUTPUT_UNDERRUN_COUNT_EN
      .underrun_count_out(underrun_count_out),
`endif
      .underrun_out(underrun_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   int          n;        // clk edges since reset release
   int          mk;       // current slot
   bit          m_full;
   logic [31:0] m_buf, m_frame;
   bit          m_cap;
   bit          e_sclk, e_bclk, e_lr, e_dout, e_ack, e_und;
   int          e_cnt;

   function automatic bit slot_bit(input logic [31:0] w, input int s);
      if (s >= 1 && s <= 16) return w[32 - s];
      if (s >= 33 && s <= 48) return w[48 - s];
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0; mk = 63; m_full = 0; m_buf = '0; m_frame = '0;
         e_sclk = 0; e_bclk = 0; e_lr = 0; e_dout = 0; e_ack = 0; e_und = 0; e_cnt = 0;
      end else begin
         n = n + 1;
         e_sclk = ((n / MCLK_DIV) % 2) == 1;
         e_bclk = ((n / BCLK_DIV) % 2) == 1;
         m_cap  = in1_stb && !m_full;
         e_und  = 0;
         if ((n % (2 * BCLK_DIV)) == 0) begin
            mk = ((n / (2 * BCLK_DIV)) - 1) % 64;
            if (mk == 0) begin
               if (m_full) m_frame = m_buf;
               else begin
                  m_frame = '0;
                  e_und = 1;
                  if (e_cnt < 65535) e_cnt++;
               end
               m_full = 0;
            end
            e_lr   = (mk >= 32);
            e_dout = slot_bit(m_frame, mk);
         end
         if (m_cap) begin
            m_buf  = in1;
            m_full = 1;
         end
         e_ack = m_cap;
      end
   end

   // ---------------- per-cycle compare + frame recorder ----------------
   logic [5:0]  dut_v, exp_v;
   logic        prev_bclk = 1'b0;
   logic [63:0] fr_vec = '0;
   logic [63:0] frames[$];
   int          und_seen = 0;
   int          ack_seen = 0;

   always @(negedge clk) begin
      dut_v = {sclk_out, bclk_out, lrclk_out, dout_out, in1_ack, underrun_out};
      exp_v = {e_sclk, e_bclk, e_lr, e_dout, e_ack, e_und};
      checks++;
      if (dut_v !== exp_v) begin
         failures++;
         $display("FAIL outputs n=%0d {sclk,bclk,lr,dout,ack,und}: got %b expected %b", n, dut_v, exp_v);
      end
`ifdef I2S_OUTPUT_UNDERRUN_COUNT_EN
      checks++;
      if (underrun_count_out !== 16'(e_cnt)) begin
         failures++;
         $display("FAIL underrun_count n=%0d: got %0d expected %0d", n, underrun_count_out, e_cnt);
      end
`endif
      if (!rst_n) begin
         fr_vec = '0;
         frames.delete();
         und_seen = 0;
         ack_seen = 0;
      end else begin
         if (underrun_out) und_seen++;
         if (in1_ack) ack_seen++;
         if (bclk_out && !prev_bclk && n >= 2 * BCLK_DIV) begin
            fr_vec[63 - mk] = dout_out;
            if (mk == 63) frames.push_back(fr_vec);
         end
      end
      prev_bclk = bclk_out;
   end

   // ---------------- helpers ----------------
   function automatic logic pick(input int sel);
      case (sel)
         0:       return sclk_out;
         1:       return bclk_out;
         default: return lrclk_out;
      endcase
   endfunction

   task automatic edge_n(input int sel, input logic lvl, output int at);
      logic prev;
      int   guard;
      bit   done;
      prev = pick(sel); guard = 0; done = 0; at = -1;
      while (!done) begin
         @(negedge clk);
         guard++;
         if (pick(sel) == lvl && prev != lvl) begin
            at = n; done = 1;
         end else if (guard > 1000) begin
            check("edge_timeout", 64'd0, 64'd1);
            done = 1;
         end
         prev = pick(sel);
      end
   endtask

   task automatic wait_ack(output int at);
      int guard;
      guard = 0; at = -1;
      while (at < 0 && guard < 400) begin
         @(negedge clk);
         guard++;
         if (in1_ack) at = n;
      end
      if (at < 0) check("ack_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_n(input int target);
      int guard;
      guard = 0;
      while (n < target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (n != target) check("wait_n_timeout", 64'(n), 64'(target));
   endtask

   task automatic wait_frames(input int cnt);
      int guard;
      guard = 0;
      while (frames.size() < cnt && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("frame_count", 64'(frames.size() >= cnt), 64'd1);
   endtask

   function automatic logic [63:0] frame_at(input int i);
      return (i < frames.size()) ? frames[i] : 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   // ---------------- directed scenarios ----------------
   int t0, t1, t2, ta, guard;

   initial begin
      rst_n = 1'b0; in1 = '0; in1_stb = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({sclk_out, bclk_out, lrclk_out, dout_out, in1_ack, underrun_out}), 64'd0);
      rst_n = 1'b1;

      // clock periods
      edge_n(0, 1'b1, t0); edge_n(0, 1'b1, t1);
      check("sclk_period", 64'(t1 - t0), 64'd2);
      edge_n(1, 1'b1, t0); edge_n(1, 1'b1, t1);
      check("bclk_period", 64'(t1 - t0), 64'd4);
      edge_n(2, 1'b1, t0); edge_n(2, 1'b0, t1); edge_n(2, 1'b1, t2);
      check("lrclk_first_rise", 64'(t0), 64'd132);
      check("lrclk_high", 64'(t1 - t0), 64'd128);
      check("lrclk_period", 64'(t2 - t0), 64'd256);

      // underrun with no words: loads at n=4,260,516
      wait_n(530);
      check("underruns_3_frames", 64'(und_seen), 64'd3);
`ifdef I2S_OUTPUT_UNDERRUN_COUNT_EN
      check("underrun_count_3", 64'(underrun_count_out), 64'd3);
`endif
      check("silent_frame0", frame_at(0), 64'd0);
      check("silent_frame1", frame_at(1), 64'd0);

      // single word then back-pressure chain
      in1 = 32'h8001_7FFE; in1_stb = 1'b1;
      wait_ack(ta); check("ack_word_8001", 64'(ta), 64'd531);
      in1 = 32'h1111_1111;
      wait_ack(ta); check("ack_after_load_1111", 64'(ta), 64'd773);
      in1 = 32'h2222_2222;
      wait_ack(ta); check("ack_after_load_2222", 64'(ta), 64'd1029);
      in1 = 32'h3C3C_0FF0;
      wait_ack(ta); check("ack_after_load_3c3c", 64'(ta), 64'd1285);
      in1_stb = 1'b0; in1 = '0;

      // capture coinciding with the frame-7 load (edge 1796, buffer empty)
      wait_n(1795);
      in1 = 32'hA5A5_C3C3; in1_stb = 1'b1;
      wait_ack(ta); check("ack_same_cycle_load", 64'(ta), 64'd1796);
      check("underrun_at_same_cycle", 64'(underrun_out), 64'd1);
      in1_stb = 1'b0; in1 = '0;

      wait_frames(9);
      check("frame3_8001_7ffe", frame_at(3), 64'h4000_8000_3FFF_0000);
      check("frame4_1111", frame_at(4), 64'h0888_8000_0888_8000);
      check("frame5_2222", frame_at(5), 64'h1111_0000_1111_0000);
      check("frame6_3c3c_0ff0", frame_at(6), 64'h1E1E_0000_07F8_0000);
      check("frame7_silent", frame_at(7), 64'd0);
      check("frame8_a5a5_c3c3", frame_at(8), 64'h52D2_8000_61E1_8000);
      check("underrun_total", 64'(und_seen), 64'd4);
      check("ack_total", 64'(ack_seen), 64'd5);
`ifdef I2S_OUTPUT_UNDERRUN_COUNT_EN
      check("underrun_count_4", 64'(underrun_count_out), 64'd4);
`endif

      // mid-frame reset at slot 20
      guard = 0;
      while (mk != 20 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      check("reached_slot20", 64'(mk), 64'd20);
      check("lrclk_at_slot20", 64'(lrclk_out), 64'd0);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", 64'({sclk_out, bclk_out, lrclk_out, dout_out, in1_ack, underrun_out}), 64'd0);
`ifdef I2S_OUTPUT_UNDERRUN_COUNT_EN
      check("async_reset_count", 64'(underrun_count_out), 64'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      guard = 0;
      ta = -1;
      while (ta < 0 && guard < 50) begin
         @(negedge clk);
         guard++;
         if (underrun_out) ta = n;
      end
      check("underrun_after_reset_n", 64'(ta), 64'd4);
      check("lrclk_slot0_after_reset", 64'(lrclk_out), 64'd0);
      wait_frames(1);
      check("silent_frame_after_reset", frame_at(0), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
